// File: rtl/nsdp_check_sequencer_pkg.sv
// Shared types and widths for the NSDP checker run-control sequencer.
package nsdp_pkg;

  localparam int ERR_WIDTH      = 15;
  localparam int ERR_DATA_WIDTH = 512;
  localparam int CTR_WIDTH      = 64;

  // Run-control states; the numeric encoding is fixed so status decoders
  // outside this block can rely on it.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  typedef logic [ERR_WIDTH-1:0]      err_code_t;
  typedef logic [ERR_DATA_WIDTH-1:0] err_data_t;
  typedef logic [CTR_WIDTH-1:0]      ctr_t;

  // A start command is honoured everywhere except during the single
  // CLEAR cycle, which always proceeds into RUN.
  function automatic logic start_accepted(state_e st, logic start);
    return start && (st != ST_CLEAR);
  endfunction

endpackage

// File: rtl/nsdp_check_sequencer_if.sv
// Command/event inputs and status outputs of the run-control sequencer.
// master = environment (reporter + checker datapath), slave = sequencer.
interface nsdp_check_sequencer_if;
  import nsdp_pkg::*;

  // Commands and checker datapath events
  logic      start;
  logic      stop;
  logic      pkt_done;
  logic      pkt_malformed;
  logic      err_valid;
  err_code_t err_code;
  err_data_t err_data;

  // Status towards the checker datapath and the AXI reporter
  logic      checker_enable;
  logic      checker_clear;
  logic      run_status;
  logic      eth_active;
  err_code_t error;
  err_data_t error_data;
  ctr_t      packets_rcvd;
  ctr_t      malformed_packets;

  modport master (
    output start, stop, pkt_done, pkt_malformed, err_valid, err_code, err_data,
    input  checker_enable, checker_clear, run_status, eth_active,
           error, error_data, packets_rcvd, malformed_packets
  );

  modport slave (
    input  start, stop, pkt_done, pkt_malformed, err_valid, err_code, err_data,
    output checker_enable, checker_clear, run_status, eth_active,
           error, error_data, packets_rcvd, malformed_packets
  );

endinterface

// File: rtl/nsdp_activity_timer.sv
// Ethernet activity tracker: eth_active stays high while packets keep
// arriving within ACTIVE_TIMEOUT cycles of each other.
module nsdp_activity_timer #(
  parameter int unsigned ACTIVE_TIMEOUT = 250000000,
  parameter int unsigned TO_WIDTH       = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic pkt_done,
  output logic eth_active
);

  localparam logic [TO_WIDTH-1:0] LAST_COUNT = TO_WIDTH'(ACTIVE_TIMEOUT - 1);

  logic [TO_WIDTH-1:0] count_q, count_d;
  logic                active_q, active_d;

  // Next-state: a packet restarts the window, otherwise count until expiry.
  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    count_d  = count_q;
    active_d = active_q;
    if (pkt_done) begin
      count_d  = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (count_q == LAST_COUNT) begin
        count_d  = '0;
        active_d = 1'b0;
      end else begin
        count_d = count_q + TO_WIDTH'(1);
      end
    end
  end

  // Counter and flag registers.
  // NOTE: sequential state uses non-blocking assignments so all flops
  // update together from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      active_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      active_q <= active_d;
    end
  end

  assign eth_active = active_q;

endmodule

// File: rtl/nsdp_check_sequencer.sv
// Run-control sequencer for the NSDP packet checker: arms the datapath,
// counts good/malformed packets, latches the first error and halts.
module nsdp_check_sequencer
  import nsdp_pkg::*;
#(
  parameter int unsigned ACTIVE_TIMEOUT = 250000000,
  parameter int unsigned TO_WIDTH       = 32,
  parameter bit          HALT_ON_ERROR  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  nsdp_check_sequencer_if.slave bus
);

  state_e    state_q, state_d;
  logic      checker_enable_q, checker_enable_d;
  logic      checker_clear_q, checker_clear_d;
  logic      run_status_q, run_status_d;
  err_code_t error_q, error_d;
  err_data_t error_data_q, error_data_d;
  ctr_t      packets_rcvd_q, packets_rcvd_d;
  ctr_t      malformed_packets_q, malformed_packets_d;
  logic      err_take;

  // Only the first non-empty error bitmap of a run is recorded.
  assign err_take = (state_q == ST_RUN) && bus.err_valid &&
                    (bus.err_code != '0) && (error_q == '0);

  // Next-state logic; start outranks stop, and error halts when enabled.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_accepted(state_q, bus.start)) state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_RUN;
      ST_RUN: begin
        if (start_accepted(state_q, bus.start)) begin
          state_d = ST_CLEAR;
        end else if (bus.stop || (HALT_ON_ERROR && err_take)) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT:  if (start_accepted(state_q, bus.start)) state_d = ST_CLEAR;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they are registered
  // yet line up with the state they describe.
  always_comb begin
    checker_clear_d  = (state_d == ST_CLEAR);
    run_status_d     = (state_d == ST_RUN);
    checker_enable_d = (state_d == ST_RUN);
  end

  // Counters and first-error latch: zeroed on entry to CLEAR, updated in RUN.
  always_comb begin
    error_d             = error_q;
    error_data_d        = error_data_q;
    packets_rcvd_d      = packets_rcvd_q;
    malformed_packets_d = malformed_packets_q;
    if (state_d == ST_CLEAR) begin
      error_d             = '0;
      error_data_d        = '0;
      packets_rcvd_d      = '0;
      malformed_packets_d = '0;
    end else if (state_q == ST_RUN) begin
      if (bus.pkt_done) begin
        packets_rcvd_d = packets_rcvd_q + CTR_WIDTH'(1);
        if (bus.pkt_malformed) begin
          malformed_packets_d = malformed_packets_q + CTR_WIDTH'(1);
        end
      end
      if (err_take) begin
        error_d      = bus.err_code;
        error_data_d = bus.err_data;
      end
    end
  end

  // State and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      checker_enable_q <= 1'b0;
      checker_clear_q  <= 1'b0;
      run_status_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      checker_enable_q <= checker_enable_d;
      checker_clear_q  <= checker_clear_d;
      run_status_q     <= run_status_d;
    end
  end

  // Counter and error registers.
  // NOTE: the 512-bit capture register is reset too; it is a visible
  // output that must read 0 after reset, not scratch storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      error_q             <= '0;
      error_data_q        <= '0;
      packets_rcvd_q      <= '0;
      malformed_packets_q <= '0;
    end else begin
      error_q             <= error_d;
      error_data_q        <= error_data_d;
      packets_rcvd_q      <= packets_rcvd_d;
      malformed_packets_q <= malformed_packets_d;
    end
  end

  nsdp_activity_timer #(
    .ACTIVE_TIMEOUT (ACTIVE_TIMEOUT),
    .TO_WIDTH       (TO_WIDTH)
  ) u_activity_timer (
    .clk        (clk),
    .reset      (reset),
    .pkt_done   (bus.pkt_done),
    .eth_active (bus.eth_active)
  );

  assign bus.checker_enable    = checker_enable_q;
  assign bus.checker_clear     = checker_clear_q;
  assign bus.run_status        = run_status_q;
  assign bus.error             = error_q;
  assign bus.error_data        = error_data_q;
  assign bus.packets_rcvd      = packets_rcvd_q;
  assign bus.malformed_packets = malformed_packets_q;

endmodule

// File: tb/tb_nsdp_check_sequencer.sv
// Scoreboard bench for nsdp_check_sequencer: a behavioural model predicts
// every post-edge output snapshot, a negedge monitor compares it.
module tb_nsdp_check_sequencer;
  import nsdp_pkg::*;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  nsdp_check_sequencer_if bus ();

  nsdp_check_sequencer #(
    .ACTIVE_TIMEOUT (TO),
    .TO_WIDTH       (32),
    .HALT_ON_ERROR  (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        en, clr, run, act;
    logic [14:0] err;
    logic [511:0] data;
    logic [63:0] pk, mal;
  } exp_t;

  exp_t exp_q[$];

  // Behavioural model of the run-control rules
  typedef enum {PH_IDLE, PH_CLEARING, PH_RUNNING, PH_HALTED} phase_e;
  phase_e       m_phase;
  logic [63:0]  m_pk, m_mal;
  logic [14:0]  m_err;
  logic [511:0] m_data;
  bit           m_seen_pkt;
  int           m_last_pkt;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic reset_model();
    m_phase    = PH_IDLE;
    m_pk       = '0;
    m_mal      = '0;
    m_err      = '0;
    m_data     = '0;
    m_seen_pkt = 1'b0;
    m_last_pkt = 0;
  endtask

  // Apply one cycle of inputs, predict the outputs after the edge, advance.
  task automatic drive(input bit st, input bit sp, input bit pd, input bit ml,
                       input bit ev, input logic [14:0] code, input logic [511:0] data);
    exp_t e;
    phase_e nxt;
    bus.start = st; bus.stop = sp; bus.pkt_done = pd; bus.pkt_malformed = ml;
    bus.err_valid = ev; bus.err_code = code; bus.err_data = data;

    nxt = m_phase;
    case (m_phase)
      PH_IDLE:     if (st) nxt = PH_CLEARING;
      PH_CLEARING: nxt = PH_RUNNING;
      PH_RUNNING: begin
        if (st) nxt = PH_CLEARING;
        else begin
          if (pd) begin
            m_pk = m_pk + 1;
            if (ml) m_mal = m_mal + 1;
          end
          if (ev && code != 0 && m_err == 0) begin
            m_err  = code;
            m_data = data;
            nxt    = PH_HALTED;
          end
          if (sp) nxt = PH_HALTED;
        end
      end
      PH_HALTED:   if (st) nxt = PH_CLEARING;
      default:     nxt = PH_IDLE;
    endcase
    if (nxt == PH_CLEARING) begin
      m_pk = '0; m_mal = '0; m_err = '0; m_data = '0;
    end
    m_phase = nxt;
    if (pd) begin
      m_seen_pkt = 1'b1;
      m_last_pkt = cyc + 1;
    end

    e.cyc  = cyc + 1;
    e.en   = (m_phase == PH_RUNNING);
    e.run  = (m_phase == PH_RUNNING);
    e.clr  = (m_phase == PH_CLEARING);
    e.act  = m_seen_pkt && ((cyc + 1 - m_last_pkt) < TO);
    e.err  = m_err;
    e.data = m_data;
    e.pk   = m_pk;
    e.mal  = m_mal;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, '0, '0);
  endtask

  task automatic clear_inputs();
    bus.start = 0; bus.stop = 0; bus.pkt_done = 0; bus.pkt_malformed = 0;
    bus.err_valid = 0; bus.err_code = '0; bus.err_data = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_enable"}, 512'(bus.checker_enable), 512'(0));
    check({tag, "_clear"}, 512'(bus.checker_clear), 512'(0));
    check({tag, "_run"}, 512'(bus.run_status), 512'(0));
    check({tag, "_active"}, 512'(bus.eth_active), 512'(0));
    check({tag, "_error"}, 512'(bus.error), 512'(0));
    check({tag, "_error_data"}, bus.error_data, 512'(0));
    check({tag, "_pkts"}, 512'(bus.packets_rcvd), 512'(0));
    check({tag, "_malformed"}, 512'(bus.malformed_packets), 512'(0));
  endtask

  // Monitor: compare the snapshot predicted for the current cycle.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) void'(exp_q.pop_front());
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      check("checker_enable", 512'(bus.checker_enable), 512'(e.en));
      check("checker_clear", 512'(bus.checker_clear), 512'(e.clr));
      check("run_status", 512'(bus.run_status), 512'(e.run));
      check("eth_active", 512'(bus.eth_active), 512'(e.act));
      check("error", 512'(bus.error), 512'(e.err));
      check("error_data", bus.error_data, e.data);
      check("packets_rcvd", 512'(bus.packets_rcvd), 512'(e.pk));
      check("malformed_packets", 512'(bus.malformed_packets), 512'(e.mal));
    end
  end

  initial begin
    exp_t patched;
    clear_inputs();
    reset = 1'b1;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    check("reset_state", 512'(dut.state_q), 512'(ST_IDLE));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 1: start -> CLEAR -> RUN
    drive(1, 0, 0, 0, 0, '0, '0);
    idle(3);

    // 2: ten packets, three malformed, then stop and freeze
    for (int i = 0; i < 10; i++) drive(0, 0, 1, (i % 3 == 1), 0, '0, '0);
    drive(0, 1, 0, 0, 0, '0, '0);
    for (int i = 0; i < 100; i++) drive(0, 0, 1, i[0], 0, '0, '0);

    // 3: first error wins and halts
    drive(1, 0, 0, 0, 0, '0, '0);
    idle(2);
    drive(0, 0, 0, 0, 1, 15'h0000, rnd512());
    drive(0, 0, 1, 0, 0, '0, '0);
    drive(0, 0, 0, 0, 1, 15'h0004, {16{32'hDEADBEEF}});
    drive(0, 0, 0, 0, 1, 15'h0010, rnd512());
    idle(3);

    // 4: pkt_done + err_valid + stop together, then restart
    drive(1, 0, 0, 0, 0, '0, '0);
    idle(1);
    drive(0, 0, 1, 1, 0, '0, '0);
    drive(0, 1, 1, 0, 1, 15'h1234, rnd512());
    idle(2);
    drive(1, 0, 0, 0, 0, '0, '0);
    idle(2);
    drive(0, 1, 0, 0, 0, '0, '0);
    drive(0, 1, 0, 0, 0, '0, '0);

    // 5: activity window and its restart
    idle(TO + 4);
    drive(0, 0, 1, 0, 0, '0, '0);
    idle(4);
    drive(0, 0, 1, 0, 0, '0, '0);
    idle(TO + 4);

    // 6a: counter wrap at 2^64
    drive(1, 0, 0, 0, 0, '0, '0);
    idle(1);
    drive(0, 0, 1, 0, 0, '0, '0);
    force dut.packets_rcvd_q = '1;
    #1;
    release dut.packets_rcvd_q;
    m_pk = '1;
    patched = exp_q.pop_back();
    patched.pk = '1;
    exp_q.push_back(patched);
    drive(0, 0, 1, 1, 0, '0, '0);
    idle(1);

    // Randomised traffic with busy and quiet phases
    for (int burst = 0; burst < 6; burst++) begin
      for (int i = 0; i < 100; i++) begin
        bit st, sp, pd, ml, ev;
        logic [14:0] code;
        st   = ($urandom % 40) == 0;
        sp   = ($urandom % 30) == 0;
        pd   = burst[0] ? (($urandom % 3) == 0) : (($urandom % 20) == 0);
        ml   = pd && (($urandom % 3) == 0);
        ev   = ($urandom % 25) == 0;
        code = (($urandom % 4) == 0) ? 15'h0 : 15'($urandom);
        drive(st, sp, pd, ml, ev, code, rnd512());
      end
    end

    // 6b: asynchronous reset in the middle of a run
    drive(1, 0, 0, 0, 0, '0, '0);
    idle(1);
    drive(0, 0, 1, 1, 1, 15'h0002, rnd512());
    drive(1, 0, 0, 0, 0, '0, '0);
    idle(1);
    drive(0, 0, 1, 0, 0, '0, '0);
    clear_inputs();
    #1;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check_all_zero("async_reset");
    check("async_reset_state", 512'(dut.state_q), 512'(ST_IDLE));
    @(negedge clk);
    reset = 1'b0;
    reset_model();
    @(posedge clk);
    #1;
    idle(2);
    drive(1, 0, 0, 0, 0, '0, '0);
    idle(3);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/nsdp_check_sequencer.md
Name: nsdp_check_sequencer

Overview:
Run-control sequencer for the NSDP packet checker; it drives the status and counter signals the AXI reporter exposes.
- Arms the checker datapath on a start command and counts good and malformed packets.
- Latches the first error code and its 512-bit error data, then halts the checker.
- Tracks Ethernet activity with an inactivity timeout.
- Sits between the checker datapath (event pulses in) and the AXI reporter (status out).

Parameters:
ACTIVE_TIMEOUT, 250000000, cycles without a received packet before eth_active drops (1 s at 250 MHz)
TO_WIDTH, 32, width of the inactivity counter; must satisfy ACTIVE_TIMEOUT < 2**TO_WIDTH
HALT_ON_ERROR, 1, 1 = halt on the first error; 0 = record the first error and keep running

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: clear counters and error state, begin a run
stop  in  1  one-cycle pulse: end the run; counters and error state hold
pkt_done  in  1  one-cycle pulse: checker finished one packet
pkt_malformed  in  1  qualifies pkt_done: packet was malformed
err_valid  in  1  one-cycle pulse: checker detected error(s)
err_code  in  15  error bitmap, sampled with err_valid
err_data  in  512  offending data beat, sampled with err_valid
checker_enable  out  1  checker datapath may consume and compare
checker_clear  out  1  one-cycle pulse: datapath reloads expected fdata/taddr/fc seeds
run_status  out  1  1 while a run is in progress
eth_active  out  1  1 = a packet was seen within ACTIVE_TIMEOUT cycles
error  out  15  latched first error bitmap (0 = no error)
error_data  out  512  data captured with the first error
packets_rcvd  out  64  count of pkt_done pulses during the run
malformed_packets  out  64  count of pkt_done & pkt_malformed during the run

Behaviour:
- Reset (asynchronous, active-high): all outputs 0, state IDLE, inactivity counter 0.
- State machine has four states: IDLE, CLEAR, RUN, HALT.
- IDLE:
  - start -> CLEAR.
  - pkt_done/err_valid are ignored, except that pkt_done still refreshes eth_active.
- CLEAR (exactly 1 cycle):
  - checker_clear=1; error, error_data and both counters zeroed.
  - Next state is RUN.
- RUN:
  - run_status=1 and checker_enable=1, both registered.
  - Both become visible 2 cycles after start: start -> CLEAR -> RUN.
- RUN, on pkt_done: packets_rcvd += 1; additionally, if pkt_malformed, malformed_packets += 1.
  - A malformed packet increments both counters.
- Counter width: counters are 64-bit and wrap modulo 2^64 with no saturation.
- RUN, on err_valid while error==0:
  - Latch err_code and err_data the same cycle; they are visible on the next cycle.
  - If HALT_ON_ERROR=1: next state HALT, and checker_enable deasserts the cycle after err_valid.
- RUN, on err_valid with err_code==0: treated as no error; nothing is latched.
- RUN, on a later err_valid while error!=0: ignored; first error wins and is never OR-merged.
- RUN, on stop -> HALT.
- HALT:
  - run_status=0, checker_enable=0.
  - error, error_data and counters are frozen and remain readable.
  - start -> CLEAR, beginning a new run.
- Simultaneous events, same cycle in RUN:
  - pkt_done + err_valid: the packet is counted and the error is latched.
  - stop + err_valid: the error is latched, then HALT.
  - stop + pkt_done: the packet is counted.
- start in RUN restarts the run (-> CLEAR); a stop coinciding with start is ignored and start wins.
- stop in IDLE/CLEAR/HALT: no effect.
- eth_active (independent of state):
  - pkt_done: counter loads 0 and eth_active=1 on the next cycle.
  - Otherwise, while eth_active=1, the counter increments.
  - When the counter reaches ACTIVE_TIMEOUT-1 with no pkt_done, eth_active=0 on the next cycle.
- Reset mid-run: immediate return to IDLE with all outputs 0; no partial state survives.
- Latency: all outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package nsdp_pkg holds:
  - state encoding constants: ST_IDLE=0, ST_CLEAR=1, ST_RUN=2, ST_HALT=3;
  - ERR_WIDTH=15, ERR_DATA_WIDTH=512, CTR_WIDTH=64.
- One natural sub-module: nsdp_activity_timer (the eth_active timeout counter), parameterised by ACTIVE_TIMEOUT and TO_WIDTH.
- Counters and error latch stay inline.

Test Plan:
1. Reset then start -> checker_clear high on cycle 1, run_status=1 and checker_enable=1 from cycle 2; all counters 0, error=0.
2. RUN with 10 pkt_done, 3 of them with pkt_malformed -> packets_rcvd=10, malformed_packets=3; stop -> HALT with values frozen over 100 further pkt_done.
3. RUN with err_valid err_code=15'h0004, err_data={16{32'hDEADBEEF}}, then err_valid err_code=15'h0010 -> error=15'h0004 with the first data retained; HALT and checker_enable=0 one cycle after the first err_valid (HALT_ON_ERROR=1).
4. Same cycle pkt_done+err_valid+stop -> packets_rcvd increments by 1, error is latched, state HALT; then start -> counters and error cleared, RUN resumes.
5. ACTIVE_TIMEOUT=8 with one pkt_done -> eth_active=1 the next cycle, 0 exactly 8 cycles after; a pkt_done at cycle 5 restarts the 8-cycle window.
6. Preload packets_rcvd=2^64-1 via force, then one pkt_done -> wraps to 0; reset asserted mid-RUN -> all outputs 0 asynchronously, state IDLE.
